// File: rtl/led_panel_pkg.sv
// Shared types for the HUB75 scan driver: scan states, shift phases, on-time counter sizing.
package led_panel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LATCH,
    DISPLAY,
    BLANK
  } scan_state_t;

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  // Wide enough for base_on_time << (color_bits-1) without overflow.
  function automatic int on_time_width(input int base_on_time, input int color_bits);
    return $clog2(base_on_time) + color_bits;
  endfunction

endpackage

// File: rtl/led_panel_scan_driver_if.sv
// Pixel-lookup bus: the scanner (master) asks for col/row/bitplane, the source (slave) answers RGB bits per half.
interface led_panel_scan_driver_if #(
  parameter int DISPLAY_ROWS_LINES = 4,
  parameter int DISPLAY_COLS_LINES = 6,
  parameter int BITPLANE_LINES     = 4
);
  logic [DISPLAY_COLS_LINES-1:0] col1, col2;
  logic [DISPLAY_ROWS_LINES-1:0] row1, row2;
  logic [BITPLANE_LINES-1:0]     bitplane1, bitplane2;
  logic red1, green1, blue1;
  logic red2, green2, blue2;

  modport master (
    output col1, col2, row1, row2, bitplane1, bitplane2,
    input  red1, green1, blue1, red2, green2, blue2
  );

  modport slave (
    input  col1, col2, row1, row2, bitplane1, bitplane2,
    output red1, green1, blue1, red2, green2, blue2
  );
endinterface

// File: rtl/led_panel_on_timer.sv
// Output-enable on-time counter: loaded on LATCH, counts down through DISPLAY, done at count 1.
module led_panel_on_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clock_clk,
  input  logic             reset_rst,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock_clk or negedge reset_rst) begin
    if (!reset_rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == WIDTH'(1));

endmodule

// File: rtl/led_panel_scan_driver.sv
// HUB75 scanner: per row pair and bitplane, shifts 2^COLS pixels (4 clks each), latches, then holds OE for
// BASE_ON_TIME<<b clocks; all panel outputs registered, enable only sampled in IDLE or at frame end.
module led_panel_scan_driver
  import led_panel_pkg::*;
#(
  parameter int DISPLAY_ROWS_LINES = 4,
  parameter int DISPLAY_COLS_LINES = 6,
  parameter int COLOR_BITS         = 8,
  parameter int BITPLANE_LINES     = 4,
  parameter int BASE_ON_TIME       = 4
) (
  input  logic                          clock_clk,
  input  logic                          reset_rst,
  input  logic                          enable,
  led_panel_scan_driver_if.master       pix,
  output logic                          panel_r1,
  output logic                          panel_g1,
  output logic                          panel_b1,
  output logic                          panel_r2,
  output logic                          panel_g2,
  output logic                          panel_b2,
  output logic                          panel_clk,
  output logic                          panel_lat,
  output logic                          panel_oe_n,
  output logic [DISPLAY_ROWS_LINES-1:0] panel_addr,
  output logic                          v_sync,
  output logic                          busy
);

  localparam int ON_W = on_time_width(BASE_ON_TIME, COLOR_BITS);
  localparam logic [DISPLAY_ROWS_LINES-1:0] R_LAST = '1;
  localparam logic [DISPLAY_COLS_LINES-1:0] C_LAST = '1;
  localparam logic [BITPLANE_LINES-1:0]     B_LAST = BITPLANE_LINES'(COLOR_BITS - 1);

  scan_state_t                   state;
  logic [1:0]                    phase;
  logic [DISPLAY_ROWS_LINES-1:0] r, row_q;
  logic [DISPLAY_COLS_LINES-1:0] c, col_q;
  logic [BITPLANE_LINES-1:0]     b, bp_q;

  logic            on_load, on_dec, on_done;
  logic [ON_W-1:0] on_val;

  assign on_load = (state == LATCH);
  assign on_dec  = (state == DISPLAY);
  assign on_val  = ON_W'(BASE_ON_TIME) << b;

  led_panel_on_timer #(.WIDTH(ON_W)) u_on_timer (
    .clock_clk (clock_clk),
    .reset_rst (reset_rst),
    .load      (on_load),
    .dec       (on_dec),
    .load_val  (on_val),
    .done      (on_done)
  );

  assign pix.col1      = col_q;
  assign pix.col2      = col_q;
  assign pix.row1      = row_q;
  assign pix.row2      = row_q;
  assign pix.bitplane1 = bp_q;
  assign pix.bitplane2 = bp_q;

  always_ff @(posedge clock_clk or negedge reset_rst) begin
    if (!reset_rst) begin
      state      <= IDLE;
      phase      <= P0;
      r          <= '0;
      c          <= '0;
      b          <= '0;
      row_q      <= '0;
      col_q      <= '0;
      bp_q       <= '0;
      panel_r1   <= 1'b0;
      panel_g1   <= 1'b0;
      panel_b1   <= 1'b0;
      panel_r2   <= 1'b0;
      panel_g2   <= 1'b0;
      panel_b2   <= 1'b0;
      panel_clk  <= 1'b0;
      panel_lat  <= 1'b0;
      panel_oe_n <= 1'b1;
      panel_addr <= '0;
      v_sync     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      v_sync <= 1'b0;
      case (state)
        IDLE: begin
          panel_oe_n <= 1'b1;
          panel_clk  <= 1'b0;
          if (enable) begin
            state <= SHIFT;
            phase <= P0;
            r     <= '0;
            c     <= '0;
            b     <= '0;
            row_q <= '0;
            col_q <= '0;
            bp_q  <= '0;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          case (phase)
            P0: phase <= P1;
            // P1 gives a one-clock-latency source time to answer before capture.
            P1: begin
              phase    <= P2;
              panel_r1 <= pix.red1;
              panel_g1 <= pix.green1;
              panel_b1 <= pix.blue1;
              panel_r2 <= pix.red2;
              panel_g2 <= pix.green2;
              panel_b2 <= pix.blue2;
            end
            P2: begin
              phase     <= P3;
              panel_clk <= 1'b1;
            end
            default: begin
              phase     <= P0;
              panel_clk <= 1'b0;
              if (c == C_LAST) begin
                state      <= LATCH;
                c          <= '0;
                panel_lat  <= 1'b1;
                panel_addr <= r;
              end else begin
                c     <= c + 1'b1;
                col_q <= c + 1'b1;
              end
            end
          endcase
        end
        LATCH: begin
          state      <= DISPLAY;
          panel_lat  <= 1'b0;
          panel_oe_n <= 1'b0;
        end
        DISPLAY: begin
          if (on_done) begin
            state      <= BLANK;
            panel_oe_n <= 1'b1;
            v_sync     <= (b == B_LAST) && (r == R_LAST);
          end
        end
        default: begin
          phase <= P0;
          c     <= '0;
          col_q <= '0;
          if (b != B_LAST) begin
            state <= SHIFT;
            b     <= b + 1'b1;
            bp_q  <= b + 1'b1;
          end else begin
            b    <= '0;
            bp_q <= '0;
            if (r != R_LAST) begin
              state <= SHIFT;
              r     <= r + 1'b1;
              row_q <= r + 1'b1;
            end else begin
              r     <= '0;
              row_q <= '0;
              if (enable) begin
                state <= SHIFT;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_panel_scan_driver.sv
// Directed bench for the scan driver on a 2-row-pair, 4-column, 2-bitplane panel with BASE_ON_TIME=2.
module tb_led_panel_scan_driver;

  localparam int RL = 1;
  localparam int CL = 2;
  localparam int CB = 2;
  localparam int BL = 2;
  localparam int BT = 2;

  // {pclk, lat, oe_n, addr, col, row, bitplane, r1 g1 b1 r2 g2 b2, v_sync, busy}
  typedef struct packed {
    logic       pclk;
    logic       lat;
    logic       oe_n;
    logic       addr;
    logic [1:0] col;
    logic       row;
    logic [1:0] bp;
    logic [5:0] data;
    logic       vs;
    logic       busy;
  } obs_t;

  typedef struct {
    int   cyc;
    logic en;
    obs_t exp;
  } vec_t;

  localparam obs_t RST_OBS = 17'b0_0_1_0_00_0_00_000000_0_0;

  logic clk = 1'b0;
  logic reset_rst;
  logic enable;
  logic panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2;
  logic panel_clk, panel_lat, panel_oe_n, v_sync, busy;
  logic [RL-1:0] panel_addr;
  logic red2_q = 1'b0;

  led_panel_scan_driver_if #(.DISPLAY_ROWS_LINES(RL), .DISPLAY_COLS_LINES(CL), .BITPLANE_LINES(BL)) pif ();

  led_panel_scan_driver #(
    .DISPLAY_ROWS_LINES(RL), .DISPLAY_COLS_LINES(CL), .COLOR_BITS(CB),
    .BITPLANE_LINES(BL), .BASE_ON_TIME(BT)
  ) dut (
    .clock_clk  (clk),
    .reset_rst  (reset_rst),
    .enable     (enable),
    .pix        (pif),
    .panel_r1   (panel_r1),
    .panel_g1   (panel_g1),
    .panel_b1   (panel_b1),
    .panel_r2   (panel_r2),
    .panel_g2   (panel_g2),
    .panel_b2   (panel_b2),
    .panel_clk  (panel_clk),
    .panel_lat  (panel_lat),
    .panel_oe_n (panel_oe_n),
    .panel_addr (panel_addr),
    .v_sync     (v_sync),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Pixel source: upper half combinational, red2 through one register stage.
  assign pif.red1   = pif.col1[0];
  assign pif.green1 = pif.bitplane1[0];
  assign pif.blue1  = pif.row1[0];
  assign pif.red2   = red2_q;
  assign pif.green2 = pif.col1[1];
  assign pif.blue2  = ~pif.col1[0];
  always @(posedge clk) red2_q <= (pif.col1 == 2'd3);

  obs_t obs;
  assign obs = {panel_clk, panel_lat, panel_oe_n, panel_addr, pif.col1, pif.row1, pif.bitplane1,
                panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2, v_sync, busy};

  int gcyc = 0;
  always @(posedge clk) gcyc++;

  int   pclk_rises = 0;
  int   rises_lat  = 0;
  int   viol       = 0;
  logic pclk_prev  = 1'b0;
  logic vs_prev    = 1'b0;
  logic addr_prev  = 1'b0;

  always @(negedge clk) begin
    if (panel_clk && !pclk_prev) begin
      pclk_rises++;
      rises_lat++;
    end
    pclk_prev = panel_clk;
    if (!reset_rst) begin
      rises_lat = 0;
      vs_prev   = 1'b0;
      addr_prev = panel_addr;
    end else begin
      if ((panel_addr != addr_prev) && !panel_oe_n) viol++;
      if (panel_lat && (panel_clk || !panel_oe_n)) viol++;
      if (panel_lat) begin
        if (rises_lat != 4) viol++;
        rises_lat = 0;
      end
      if (v_sync && vs_prev) viol++;
      if ((pif.col2 != pif.col1) || (pif.row2 != pif.row1) || (pif.bitplane2 != pif.bitplane1)) viol++;
      vs_prev   = v_sync;
      addr_prev = panel_addr;
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [24];

  initial begin
    int n, k, t1, t2, t3, r0;
    vecs[0]  = '{1,  1'b1, 17'b0_0_1_0_00_0_00_000000_0_1};
    vecs[1]  = '{3,  1'b1, 17'b0_0_1_0_00_0_00_000001_0_1};
    vecs[2]  = '{4,  1'b1, 17'b1_0_1_0_00_0_00_000001_0_1};
    vecs[3]  = '{8,  1'b1, 17'b1_0_1_0_01_0_00_100000_0_1};
    vecs[4]  = '{11, 1'b1, 17'b0_0_1_0_10_0_00_000011_0_1};
    vecs[5]  = '{16, 1'b1, 17'b1_0_1_0_11_0_00_100110_0_1};
    vecs[6]  = '{17, 1'b1, 17'b0_1_1_0_11_0_00_100110_0_1};
    vecs[7]  = '{18, 1'b1, 17'b0_0_0_0_11_0_00_100110_0_1};
    vecs[8]  = '{19, 1'b1, 17'b0_0_0_0_11_0_00_100110_0_1};
    vecs[9]  = '{20, 1'b1, 17'b0_0_1_0_11_0_00_100110_0_1};
    vecs[10] = '{21, 1'b1, 17'b0_0_1_0_00_0_01_100110_0_1};
    vecs[11] = '{23, 1'b1, 17'b0_0_1_0_00_0_01_010001_0_1};
    vecs[12] = '{37, 1'b1, 17'b0_1_1_0_11_0_01_110110_0_1};
    vecs[13] = '{38, 1'b1, 17'b0_0_0_0_11_0_01_110110_0_1};
    vecs[14] = '{41, 1'b1, 17'b0_0_0_0_11_0_01_110110_0_1};
    vecs[15] = '{42, 1'b1, 17'b0_0_1_0_11_0_01_110110_0_1};
    vecs[16] = '{43, 1'b1, 17'b0_0_1_0_00_1_00_110110_0_1};
    vecs[17] = '{45, 1'b1, 17'b0_0_1_0_00_1_00_001001_0_1};
    vecs[18] = '{59, 1'b1, 17'b0_1_1_1_11_1_00_101110_0_1};
    vecs[19] = '{62, 1'b1, 17'b0_0_1_1_11_1_00_101110_0_1};
    vecs[20] = '{79, 1'b1, 17'b0_1_1_1_11_1_01_111110_0_1};
    vecs[21] = '{83, 1'b1, 17'b0_0_0_1_11_1_01_111110_0_1};
    vecs[22] = '{84, 1'b1, 17'b0_0_1_1_11_1_01_111110_1_1};
    vecs[23] = '{85, 1'b1, 17'b0_0_1_1_00_0_00_111110_0_1};

    // Reset held, then released with enable low.
    reset_rst = 1'b0;
    enable    = 1'b0;
    repeat (5) step();
    check("reset_outputs", 32'(obs), 32'(RST_OBS));
    @(negedge clk) reset_rst = 1'b1;
    repeat (3) step();
    check("idle_outputs", 32'(obs), 32'(RST_OBS));
    check("idle_no_pclk", pclk_rises, 0);

    // First frame, cycle-accurate.
    n = 0;
    for (int i = 0; i < 24; i++) begin
      enable = vecs[i].en;
      while (n < vecs[i].cyc) begin
        step();
        n++;
      end
      check($sformatf("vec_cyc%0d", vecs[i].cyc), 32'(obs), 32'(vecs[i].exp));
    end

    // Free-run frame period.
    k = 0;
    while (!v_sync && k < 200) begin step(); k++; end
    check("vsync_seen_1", 32'(v_sync), 1);
    t1 = gcyc;
    k = 0;
    step();
    while (!v_sync && k < 200) begin step(); k++; end
    check("vsync_seen_2", 32'(v_sync), 1);
    t2 = gcyc;
    check("vsync_period", t2 - t1, 84);

    // Enable dropped and toggled mid-frame: frame still completes, then IDLE.
    repeat (10) step();
    enable = 1'b0;
    repeat (20) step();
    enable = 1'b1;
    repeat (10) step();
    enable = 1'b0;
    k = 0;
    while (!v_sync && k < 200) begin step(); k++; end
    t3 = gcyc;
    check("drop_frame_len", t3 - t2, 84);
    step();
    check("drop_idle_busy", 32'(busy), 0);
    check("drop_idle_oe", 32'(panel_oe_n), 1);
    r0 = pclk_rises;
    repeat (20) step();
    check("drop_idle_quiet", pclk_rises - r0, 0);
    check("drop_idle_stays", 32'(busy), 0);

    // Reset during row-pair 1 display, then restart from the top.
    enable = 1'b1;
    k = 0;
    while (!((panel_addr == 1'b1) && !panel_oe_n) && k < 300) begin step(); k++; end
    check("reach_row1_display", 32'(panel_oe_n), 0);
    #1 reset_rst = 1'b0;
    #1 check("async_reset", 32'(obs), 32'(RST_OBS));
    @(negedge clk) reset_rst = 1'b1;
    step();
    check("restart_first", 32'(obs), 32'(17'b0_0_1_0_00_0_00_000000_0_1));
    k = 1;
    while (!panel_lat && k < 40) begin step(); k++; end
    check("restart_latch_cycle", k, 17);
    check("restart_addr", 32'(panel_addr), 0);

    check("invariants", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
